// File: rtl/snn_layer_mac_if.sv
// Handshake and memory-port bundle between the spiking-layer MAC and its environment.
// master = MAC side (issues ROM/spike addresses, reports activations); slave = environment side.
`timescale 1ns/1ps
interface snn_layer_mac_if #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 8
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] rom_addr;
   logic [DATA_WIDTH-1:0] rom_q;
   logic [9:0]            in_addr;
   logic                  in_bit;
   logic                  busy;
   logic                  out_valid;
   logic [4:0]            out_idx;
   logic [7:0]            out_val;
   logic                  done;

   modport master (
      input  start, rom_q, in_bit,
      output rom_addr, in_addr, busy, out_valid, out_idx, out_val, done
   );

   modport slave (
      output start, rom_q, in_bit,
      input  rom_addr, in_addr, busy, out_valid, out_idx, out_val, done
   );
endinterface

// File: rtl/snn_layer_mac.sv
// Sequential spike-gated MAC: one neuron per NUM_INPUTS+2 cycles, clamped 8-bit activation strobed in EMIT.
// No backpressure: the ROM and spike buffer are assumed to answer every address one cycle later.
`timescale 1ns/1ps
module snn_layer_mac #(
   parameter int NUM_INPUTS  = 784,
   parameter int NUM_NEURONS = 32,
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 15,
   parameter int SHIFT       = 4
) (
   input logic clk,
   input logic rst,
   snn_layer_mac_if.master bus
);
   typedef enum logic [2:0] {IDLE, RUN, DRAIN, EMIT, FIN} state_t;

   localparam logic [9:0]            LAST_I = 10'(NUM_INPUTS - 1);
   localparam logic [4:0]            LAST_N = 5'(NUM_NEURONS - 1);
   localparam logic [ADDR_WIDTH-1:0] NI     = ADDR_WIDTH'(NUM_INPUTS);

   state_t                  state, state_nxt;
   logic [4:0]              n;
   logic [9:0]              i;
   logic                    tag;
   logic signed [17:0]      acc;
   logic signed [17:0]      shifted;
   logic signed [17:0]      weight;
   logic [7:0]              clamped;
   logic [ADDR_WIDTH-1:0]   addr_hold, rom_addr_c;
   logic [9:0]              in_hold, in_addr_c;
   logic [4:0]              idx_hold, out_idx_c;
   logic [7:0]              val_hold, out_val_c;

   assign weight  = $signed({{(18-DATA_WIDTH){bus.rom_q[DATA_WIDTH-1]}}, bus.rom_q});
   assign shifted = acc >>> SHIFT;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (i == LAST_I) state_nxt = DRAIN;
         DRAIN:   state_nxt = EMIT;
         EMIT:    state_nxt = (n == LAST_N) ? FIN : RUN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      clamped = shifted[7:0];
      if (shifted[17])
         clamped = 8'd0;
      else if (shifted > 18'sd255)
         clamped = 8'hFF;
   end

   // Address and result outputs are live only in their own state and hold otherwise.
   always_comb begin
      rom_addr_c = addr_hold;
      in_addr_c  = in_hold;
      out_idx_c  = idx_hold;
      out_val_c  = val_hold;
      if (state == RUN) begin
         rom_addr_c = ADDR_WIDTH'(n) * NI + ADDR_WIDTH'(i);
         in_addr_c  = i;
      end
      if (state == EMIT) begin
         out_idx_c = n;
         out_val_c = clamped;
      end
   end

   assign bus.rom_addr  = rom_addr_c;
   assign bus.in_addr   = in_addr_c;
   assign bus.out_idx   = out_idx_c;
   assign bus.out_val   = out_val_c;
   assign bus.out_valid = (state == EMIT);
   assign bus.busy      = (state == RUN) || (state == DRAIN) || (state == EMIT);
   assign bus.done      = (state == FIN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         n         <= '0;
         i         <= '0;
         tag       <= 1'b0;
         acc       <= '0;
         addr_hold <= '0;
         in_hold   <= '0;
         idx_hold  <= '0;
         val_hold  <= '0;
      end else begin
         state     <= state_nxt;
         tag       <= (state == RUN);
         addr_hold <= rom_addr_c;
         in_hold   <= in_addr_c;
         idx_hold  <= out_idx_c;
         val_hold  <= out_val_c;
         // The tag lines up with the data returned for the previous cycle's address.
         if (tag && bus.in_bit)
            acc <= acc + weight;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  n   <= '0;
                  i   <= '0;
                  acc <= '0;
               end
            end
            RUN:  i <= i + 10'd1;
            EMIT: begin
               acc <= '0;
               i   <= '0;
               if (n != LAST_N)
                  n <= n + 5'd1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_snn_layer_mac.sv
// Directed bench: NUM_INPUTS=4, NUM_NEURONS=2; SHIFT=0 DUT plus a SHIFT=2 twin on the same stimulus.
`timescale 1ns/1ps
module tb_snn_layer_mac;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   always #5 clk = ~clk;

   snn_layer_mac_if #(.ADDR_WIDTH(15), .DATA_WIDTH(8)) b0 ();
   snn_layer_mac_if #(.ADDR_WIDTH(15), .DATA_WIDTH(8)) b2 ();

   snn_layer_mac #(.NUM_INPUTS(4), .NUM_NEURONS(2), .DATA_WIDTH(8), .ADDR_WIDTH(15), .SHIFT(0))
      dut (.clk(clk), .rst(rst), .bus(b0.master));
   snn_layer_mac #(.NUM_INPUTS(4), .NUM_NEURONS(2), .DATA_WIDTH(8), .ADDR_WIDTH(15), .SHIFT(2))
      dut2 (.clk(clk), .rst(rst), .bus(b2.master));

   assign b0.start = start;
   assign b2.start = start;

   logic signed [7:0] rom [0:7];
   logic              spk [0:3];

   always @(posedge clk) begin
      b0.rom_q  <= rom[b0.rom_addr[2:0]];
      b0.in_bit <= spk[b0.in_addr[1:0]];
      b2.rom_q  <= rom[b2.rom_addr[2:0]];
      b2.in_bit <= spk[b2.in_addr[1:0]];
   end

   int asserts = 0;
   int fails = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Passive monitor; tests snapshot the counters and look at what was added.
   int ns = 0, ns2 = 0, ndone = 0, done_cyc = 0, nbusy = 0, na = 0;
   int s_idx [64], s_val [64], s_cyc [64], s2_val [64], alog [256];
   always @(negedge clk) begin
      if (b0.out_valid) begin
         s_idx[ns % 64] = int'(b0.out_idx);
         s_val[ns % 64] = int'(b0.out_val);
         s_cyc[ns % 64] = cyc;
         ns++;
      end
      if (b2.out_valid) begin
         s2_val[ns2 % 64] = int'(b2.out_val);
         ns2++;
      end
      if (b0.done) begin
         ndone++;
         done_cyc = cyc;
      end
      if (b0.busy) begin
         alog[na % 256] = int'(b0.rom_addr);
         na++;
         nbusy++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(output int c0);
      start = 1'b1;
      tick();
      start = 1'b0;
      c0 = cyc;
   endtask

   task automatic wait_done();
      int base = ndone;
      int k = 0;
      while (ndone == base && k < 40) begin
         tick();
         k++;
      end
      asserts++;
      if (ndone == base) begin fails++; $display("FAIL wait_done: done not seen within %0d cycles", k); end
   endtask

   task automatic load(input logic signed [7:0] w [0:7], input logic s [0:3]);
      for (int k = 0; k < 8; k++) rom[k] = w[k];
      for (int k = 0; k < 4; k++) spk[k] = s[k];
   endtask

   task automatic check_outputs_zero(input string tag);
      asserts++; if (b0.rom_addr !== 15'd0) begin fails++; $display("FAIL %s rom_addr: got %0d want 0", tag, b0.rom_addr); end
      asserts++; if (b0.in_addr !== 10'd0) begin fails++; $display("FAIL %s in_addr: got %0d want 0", tag, b0.in_addr); end
      asserts++; if (b0.busy !== 1'b0) begin fails++; $display("FAIL %s busy: got %b want 0", tag, b0.busy); end
      asserts++; if (b0.out_valid !== 1'b0) begin fails++; $display("FAIL %s out_valid: got %b want 0", tag, b0.out_valid); end
      asserts++; if (b0.out_idx !== 5'd0) begin fails++; $display("FAIL %s out_idx: got %0d want 0", tag, b0.out_idx); end
      asserts++; if (b0.out_val !== 8'd0) begin fails++; $display("FAIL %s out_val: got %0d want 0", tag, b0.out_val); end
      asserts++; if (b0.done !== 1'b0) begin fails++; $display("FAIL %s done: got %b want 0", tag, b0.done); end
   endtask

   task automatic run_and_check(input string tag, input int v0, input int v1, input int w0, input int w1);
      int c0, bs, bs2, bb, bd;
      bs = ns; bs2 = ns2; bb = nbusy; bd = ndone;
      do_start(c0);
      wait_done();
      asserts++; if (ns - bs !== 2) begin fails++; $display("FAIL %s strobes: got %0d want 2", tag, ns - bs); end
      asserts++; if (s_idx[bs % 64] !== 0 || s_idx[(bs + 1) % 64] !== 1) begin fails++; $display("FAIL %s idx: got %0d,%0d want 0,1", tag, s_idx[bs % 64], s_idx[(bs + 1) % 64]); end
      asserts++; if (s_val[bs % 64] !== v0) begin fails++; $display("FAIL %s n0 val: got %0d want %0d", tag, s_val[bs % 64], v0); end
      asserts++; if (s_val[(bs + 1) % 64] !== v1) begin fails++; $display("FAIL %s n1 val: got %0d want %0d", tag, s_val[(bs + 1) % 64], v1); end
      asserts++; if (s2_val[bs2 % 64] !== w0) begin fails++; $display("FAIL %s shift2 n0 val: got %0d want %0d", tag, s2_val[bs2 % 64], w0); end
      asserts++; if (s2_val[(bs2 + 1) % 64] !== w1) begin fails++; $display("FAIL %s shift2 n1 val: got %0d want %0d", tag, s2_val[(bs2 + 1) % 64], w1); end
      asserts++; if (nbusy - bb !== 12) begin fails++; $display("FAIL %s busy cycles: got %0d want 12", tag, nbusy - bb); end
      asserts++; if (ndone - bd !== 1) begin fails++; $display("FAIL %s done count: got %0d want 1", tag, ndone - bd); end
   endtask

   logic signed [7:0] w_basic [0:7] = '{8'sd10, 8'sd20, 8'sd30, 8'sd40, -8'sd50, -8'sd50, 8'sd10, 8'sd0};
   logic signed [7:0] w_max   [0:7] = '{8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127};
   logic s_1011 [0:3] = '{1'b1, 1'b0, 1'b1, 1'b1};
   logic s_1111 [0:3] = '{1'b1, 1'b1, 1'b1, 1'b1};
   logic s_0000 [0:3] = '{1'b0, 1'b0, 1'b0, 1'b0};

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      check_outputs_zero("reset_held");
      rst = 1'b0;
      repeat (2) tick();
      check_outputs_zero("reset_released");
   endtask

   task automatic test_basic();
      int c0, bs, bd;
      load(w_basic, s_1011);
      bs = ns; bd = ndone;
      do_start(c0);
      repeat (7) tick();
      asserts++; if (b0.rom_addr !== 15'd5 || b0.in_addr !== 10'd1) begin fails++; $display("FAIL basic n1 addr: got %0d/%0d want 5/1", b0.rom_addr, b0.in_addr); end
      asserts++; if (b0.out_val !== 8'd80 || b0.out_idx !== 5'd0 || b0.out_valid !== 1'b0) begin fails++; $display("FAIL basic hold: got val %0d idx %0d vld %b want 80 0 0", b0.out_val, b0.out_idx, b0.out_valid); end
      wait_done();
      asserts++; if (s_val[bs % 64] !== 80 || s_idx[bs % 64] !== 0) begin fails++; $display("FAIL basic n0: got idx %0d val %0d want 0 80", s_idx[bs % 64], s_val[bs % 64]); end
      asserts++; if (s_cyc[bs % 64] - c0 !== 5) begin fails++; $display("FAIL basic latency: got %0d want 5", s_cyc[bs % 64] - c0); end
      asserts++; if (s_val[(bs + 1) % 64] !== 0 || s_idx[(bs + 1) % 64] !== 1) begin fails++; $display("FAIL basic n1 clamp low: got idx %0d val %0d want 1 0", s_idx[(bs + 1) % 64], s_val[(bs + 1) % 64]); end
      asserts++; if (ndone - bd !== 1 || done_cyc - s_cyc[(bs + 1) % 64] !== 1) begin fails++; $display("FAIL basic done timing: got count %0d offset %0d want 1 1", ndone - bd, done_cyc - s_cyc[(bs + 1) % 64]); end
      asserts++; if (b0.busy !== 1'b0 || b0.out_idx !== 5'd1 || b0.out_val !== 8'd0) begin fails++; $display("FAIL basic after: got busy %b idx %0d val %0d want 0 1 0", b0.busy, b0.out_idx, b0.out_val); end
   endtask

   task automatic test_back_to_back();
      load(w_basic, s_1011);
      run_and_check("spikes_1011", 80, 0, 20, 0);
      load(w_basic, s_1111);
      run_and_check("spikes_1111", 100, 0, 25, 0);
   endtask

   task automatic test_clamp_high();
      load(w_max, s_1111);
      run_and_check("clamp_high", 255, 255, 127, 127);
   endtask

   task automatic test_start_mid_run();
      int c0, bs, bd, ba;
      int exp_addr [12] = '{0, 1, 2, 3, 3, 3, 4, 5, 6, 7, 7, 7};
      load(w_basic, s_1011);
      bs = ns; bd = ndone; ba = na;
      do_start(c0);
      repeat (2) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      asserts++; if (b0.done !== 1'b1) begin fails++; $display("FAIL midstart done at +12: got %b want 1", b0.done); end
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      asserts++; if (b0.busy !== 1'b0) begin fails++; $display("FAIL start_on_done ignored: busy %b want 0", b0.busy); end
      asserts++; if (ns - bs !== 2 || ndone - bd !== 1) begin fails++; $display("FAIL midstart counts: strobes %0d done %0d want 2 1", ns - bs, ndone - bd); end
      asserts++; if (na - ba !== 12) begin fails++; $display("FAIL midstart busy cycles: got %0d want 12", na - ba); end
      for (int k = 0; k < 12; k++) begin
         asserts++;
         if (alog[(ba + k) % 256] !== exp_addr[k]) begin fails++; $display("FAIL midstart rom_addr[%0d]: got %0d want %0d", k, alog[(ba + k) % 256], exp_addr[k]); end
      end
   endtask

   task automatic test_reset_mid_run();
      int c0, bs, bd;
      load(w_basic, s_1011);
      do_start(c0);
      repeat (8) tick();
      rst = 1'b1;
      #1;
      check_outputs_zero("reset_mid_run");
      bs = ns; bd = ndone;
      repeat (2) tick();
      rst = 1'b0;
      repeat (20) tick();
      asserts++; if (ns !== bs || ndone !== bd || b0.busy !== 1'b0) begin fails++; $display("FAIL reset abort: strobes %0d done %0d busy %b want 0 0 0", ns - bs, ndone - bd, b0.busy); end
      run_and_check("after_reset", 80, 0, 20, 0);
   endtask

   task automatic test_zero_spikes();
      load(w_basic, s_0000);
      run_and_check("zero_spikes", 0, 0, 0, 0);
   endtask

   initial begin
      load(w_basic, s_0000);
      test_reset();
      test_basic();
      test_back_to_back();
      test_clamp_high();
      test_start_mid_run();
      test_reset_mid_run();
      test_zero_spikes();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
